// File: rtl/pipe_ctrl_if.sv
// Hazard-side inputs and per-stage control outputs of the pipeline sequencer.
// The hazard unit / bench side is master; the sequencer is slave.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       flag_hold;
  logic             flag_flush;
  logic             mem_busy;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output flag_hold, flag_flush, mem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  flag_hold, flag_flush, mem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline: boot warm-up, freeze/flush/load-use
// arbitration with flush retention across freezes, and saturating stall/flush counters.
module pipe_ctrl #(
  parameter int FILL_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input logic          sys_clk,
  input logic          sys_arstn,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WARMUP = 2'b01,
    RUN    = 2'b10
  } state_t;

  localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYCLES - 1);

  state_t           state, state_nxt;
  logic             booted, booted_nxt;
  logic             flush_pend, flush_pend_nxt;
  logic [FW-1:0]    fill_cnt, fill_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_inc, flush_inc;

  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;

  wire stop      = bus.flag_hold[2];
  wire freeze    = bus.mem_busy | bus.flag_hold[1];
  wire eff_flush = bus.flag_flush | flush_pend;

  // NOTE: asynchronous active-low reset lives in the sensitivity list; state uses
  // non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state      <= IDLE;
      booted     <= 1'b0;
      flush_pend <= 1'b0;
      fill_cnt   <= FILL_LAST;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      booted     <= booted_nxt;
      flush_pend <= flush_pend_nxt;
      fill_cnt   <= fill_cnt_nxt;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt      = state;
    booted_nxt     = booted;
    flush_pend_nxt = flush_pend;
    fill_cnt_nxt   = fill_cnt;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    pc_en          = 1'b0;
    if_id_en       = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_en       = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_en      = 1'b0;
    mem_wb_en      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!stop) begin
          if (booted) begin
            state_nxt = RUN;
          end else begin
            state_nxt    = WARMUP;
            fill_cnt_nxt = FILL_LAST;
          end
        end
      end

      WARMUP: begin
        // Stage registers load NOPs while the front end fills; PC holds.
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if (stop) begin
          state_nxt = IDLE;
        end else if (fill_cnt == '0) begin
          state_nxt  = RUN;
          booted_nxt = 1'b1;
        end else begin
          fill_cnt_nxt = fill_cnt - 1'b1;
        end
      end

      RUN: begin
        if (stop || freeze) begin
          // A stop cycle behaves as a freeze so a simultaneous flush is not lost.
          if (stop) state_nxt = IDLE;
          if (bus.flag_flush) flush_pend_nxt = 1'b1;
          stall_inc = 1'b1;
        end else if (eff_flush) begin
          pc_en          = 1'b1;
          if_id_en       = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_en       = 1'b1;
          id_ex_flush    = 1'b1;
          ex_mem_en      = 1'b1;
          mem_wb_en      = 1'b1;
          flush_pend_nxt = 1'b0;
          flush_inc      = 1'b1;
        end else if (bus.flag_hold[0]) begin
          // Load-use: hold PC and IF/ID, inject a bubble into ID/EX.
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          stall_inc   = 1'b1;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.ctrl_state  = state;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot, load-use, flush priority, flush retention
// across freezes, resume without warm-up, counter saturation and asynchronous reset.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] O_ZERO  = 7'b0000000;
  localparam logic [6:0] O_WARM  = 7'b0111111;
  localparam logic [6:0] O_NORM  = 7'b1101011;
  localparam logic [6:0] O_FLUSH = 7'b1111111;
  localparam logic [6:0] O_LU    = 7'b0001111;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WARM = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  logic sys_clk;
  logic sys_arstn;
  int   n_pass;
  int   n_total;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.FILL_CYCLES(4), .CNT_W(CNT_W)) dut (
    .sys_clk   (sys_clk),
    .sys_arstn (sys_arstn),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [8:0] snap();
    return {bus.ctrl_state, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
            bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_en};
  endfunction

  // Advance one clock and settle 1 time unit past the edge.
  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_arstn      = 1'b0;
    bus.flag_hold  = 3'b100;
    bus.flag_flush = 1'b0;
    bus.mem_busy   = 1'b0;
    cycle();
    sys_arstn = 1'b1;
  endtask

  // Reset, release the start hold and run through the 4-cycle warm-up into RUN.
  task automatic goto_run();
    apply_reset();
    bus.flag_hold = 3'b000;
    repeat (5) cycle();
  endtask

  task automatic test_reset();
    sys_arstn      = 1'b0;
    bus.flag_hold  = 3'b100;
    bus.flag_flush = 1'b0;
    bus.mem_busy   = 1'b0;
    #2;
    n_total++;
    if (snap() !== {S_IDLE, O_ZERO}) $display("FAIL reset_outs: got %b expected %b", snap(), {S_IDLE, O_ZERO});
    else n_pass++;
    n_total++;
    if ({bus.stall_cnt, bus.flush_cnt} !== 8'h00)
      $display("FAIL reset_cnts: got %h expected 00", {bus.stall_cnt, bus.flush_cnt});
    else n_pass++;
    cycle();
    sys_arstn = 1'b1;
  endtask

  task automatic test_boot();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      #2;
      n_total++;
      if (snap() !== {S_IDLE, O_ZERO}) $display("FAIL boot_idle[%0d]: got %b expected %b", i, snap(), {S_IDLE, O_ZERO});
      else n_pass++;
      cycle();
    end
    bus.flag_hold = 3'b000;
    #2;
    n_total++;
    if (snap() !== {S_IDLE, O_ZERO}) $display("FAIL boot_release: got %b expected %b", snap(), {S_IDLE, O_ZERO});
    else n_pass++;
    cycle();
    for (int i = 0; i < 4; i++) begin
      #2;
      n_total++;
      if (snap() !== {S_WARM, O_WARM}) $display("FAIL boot_warm[%0d]: got %b expected %b", i, snap(), {S_WARM, O_WARM});
      else n_pass++;
      cycle();
    end
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_NORM}) $display("FAIL boot_run: got %b expected %b", snap(), {S_RUN, O_NORM});
    else n_pass++;
    n_total++;
    if (bus.stall_cnt !== 4'd0) $display("FAIL boot_stall: got %0d expected 0", bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_load_use();
    goto_run();
    bus.flag_hold = 3'b001;
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_LU}) $display("FAIL lu_outs: got %b expected %b", snap(), {S_RUN, O_LU});
    else n_pass++;
    cycle();
    bus.flag_hold = 3'b000;
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_NORM}) $display("FAIL lu_after: got %b expected %b", snap(), {S_RUN, O_NORM});
    else n_pass++;
    n_total++;
    if (bus.stall_cnt !== 4'd1) $display("FAIL lu_stall: got %0d expected 1", bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_flush_vs_load_use();
    goto_run();
    bus.flag_hold  = 3'b001;
    bus.flag_flush = 1'b1;
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_FLUSH}) $display("FAIL fvl_outs: got %b expected %b", snap(), {S_RUN, O_FLUSH});
    else n_pass++;
    cycle();
    bus.flag_hold  = 3'b000;
    bus.flag_flush = 1'b0;
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_NORM}) $display("FAIL fvl_after: got %b expected %b", snap(), {S_RUN, O_NORM});
    else n_pass++;
    n_total++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {4'd0, 4'd1})
      $display("FAIL fvl_cnts: got stall=%0d flush=%0d expected stall=0 flush=1", bus.stall_cnt, bus.flush_cnt);
    else n_pass++;
  endtask

  task automatic test_flush_in_freeze();
    goto_run();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.flag_flush = (i == 1);
      #2;
      n_total++;
      if (snap() !== {S_RUN, O_ZERO}) $display("FAIL frz_outs[%0d]: got %b expected %b", i, snap(), {S_RUN, O_ZERO});
      else n_pass++;
      cycle();
    end
    bus.mem_busy   = 1'b0;
    bus.flag_flush = 1'b0;
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_FLUSH}) $display("FAIL frz_pend_flush: got %b expected %b", snap(), {S_RUN, O_FLUSH});
    else n_pass++;
    n_total++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {4'd3, 4'd0})
      $display("FAIL frz_cnts: got stall=%0d flush=%0d expected stall=3 flush=0", bus.stall_cnt, bus.flush_cnt);
    else n_pass++;
    cycle();
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_NORM}) $display("FAIL frz_after: got %b expected %b", snap(), {S_RUN, O_NORM});
    else n_pass++;
    n_total++;
    if (bus.flush_cnt !== 4'd1) $display("FAIL frz_flush_cnt: got %0d expected 1", bus.flush_cnt);
    else n_pass++;
  endtask

  // Two flushes during one external hold collapse to one, applied once.
  task automatic test_flush_collapse();
    goto_run();
    bus.flag_hold  = 3'b010;
    bus.flag_flush = 1'b1;
    repeat (2) cycle();
    bus.flag_hold  = 3'b000;
    bus.flag_flush = 1'b0;
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_FLUSH}) $display("FAIL col_first: got %b expected %b", snap(), {S_RUN, O_FLUSH});
    else n_pass++;
    cycle();
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_NORM}) $display("FAIL col_second: got %b expected %b", snap(), {S_RUN, O_NORM});
    else n_pass++;
    n_total++;
    if (bus.flush_cnt !== 4'd1) $display("FAIL col_cnt: got %0d expected 1", bus.flush_cnt);
    else n_pass++;
  endtask

  task automatic test_resume();
    goto_run();
    bus.flag_hold = 3'b100;
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_ZERO}) $display("FAIL res_stop: got %b expected %b", snap(), {S_RUN, O_ZERO});
    else n_pass++;
    cycle();
    #2;
    n_total++;
    if (snap() !== {S_IDLE, O_ZERO}) $display("FAIL res_idle: got %b expected %b", snap(), {S_IDLE, O_ZERO});
    else n_pass++;
    cycle();
    bus.flag_hold = 3'b000;
    cycle();
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_NORM}) $display("FAIL res_run: got %b expected %b", snap(), {S_RUN, O_NORM});
    else n_pass++;
  endtask

  task automatic test_saturation();
    goto_run();
    bus.mem_busy = 1'b1;
    repeat (20) cycle();
    bus.mem_busy = 1'b0;
    #2;
    n_total++;
    if (bus.stall_cnt !== 4'd15) $display("FAIL sat_stall: got %0d expected 15", bus.stall_cnt);
    else n_pass++;
  endtask

  // Pending flush and counters are discarded by reset; reset mid-warm-up is immediate.
  task automatic test_reset_discard();
    goto_run();
    bus.mem_busy   = 1'b1;
    bus.flag_flush = 1'b1;
    cycle();
    bus.mem_busy   = 1'b0;
    bus.flag_flush = 1'b0;
    bus.flag_hold  = 3'b100;
    #2;
    sys_arstn = 1'b0;
    #1;
    n_total++;
    if (bus.stall_cnt !== 4'd0) $display("FAIL rst_stall: got %0d expected 0", bus.stall_cnt);
    else n_pass++;
    cycle();
    sys_arstn     = 1'b1;
    bus.flag_hold = 3'b000;
    repeat (2) cycle();
    #2;
    n_total++;
    if (snap() !== {S_WARM, O_WARM}) $display("FAIL rst_warm: got %b expected %b", snap(), {S_WARM, O_WARM});
    else n_pass++;
    sys_arstn = 1'b0;
    #1;
    n_total++;
    if (snap() !== {S_IDLE, O_ZERO}) $display("FAIL rst_mid_warm: got %b expected %b", snap(), {S_IDLE, O_ZERO});
    else n_pass++;
    cycle();
    sys_arstn = 1'b1;
    repeat (5) cycle();
    #2;
    n_total++;
    if (snap() !== {S_RUN, O_NORM}) $display("FAIL rst_no_pend: got %b expected %b", snap(), {S_RUN, O_NORM});
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_boot();
    test_load_use();
    test_flush_vs_load_use();
    test_flush_in_freeze();
    test_flush_collapse();
    test_resume();
    test_saturation();
    test_reset_discard();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core.
- Consumes the hazard unit's flag_hold[2:0] and flag_flush, plus the data-memory busy signal.
- Drives per-stage enable/flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns boot warm-up, flush retention across freezes, and stall/flush performance counters.

Parameters:
- FILL_CYCLES, 4, number of warm-up cycles with all stage registers flushed after first start.
- CNT_W, 16, width of saturating performance counters.

Ports:
- sys_clk  input  1  clock; reset sys_arstn, asynchronous, active-low; clock sys_clk.
- sys_arstn  input  1  asynchronous active-low reset.
- flag_hold  input  3  bit2 = not-started, bit1 = external hold, bit0 = load-use hold pulse.
- flag_flush  input  1  branch/jump taken in EX; kill wrong-path instructions.
- mem_busy  input  1  data memory not ready; freeze whole pipeline.
- pc_en  output  1  PC update enable.
- if_id_en  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID clear to NOP.
- id_ex_en  output  1  ID/EX load enable.
- id_ex_flush  output  1  ID/EX clear to NOP (bubble).
- ex_mem_en  output  1  EX/MEM load enable.
- mem_wb_en  output  1  MEM/WB load enable.
- ctrl_state  output  2  00 IDLE, 01 WARMUP, 10 RUN.
- stall_cnt  output  CNT_W  RUN cycles with pc_en=0, saturating.
- flush_cnt  output  CNT_W  applied flushes, saturating.

Behaviour:
- Reset: state IDLE, booted=0, flush_pend=0, counters 0. All outputs 0.
- Outputs are combinational from state, registered flags and current inputs (zero latency). State, booted, flush_pend and counters update on the rising edge.
- IDLE: all en=0, all flush=0.
  - If flag_hold[2]=0 and booted=0, go to WARMUP.
  - If flag_hold[2]=0 and booted=1, go to RUN.
- WARMUP: pc_en=0; if_id_flush=id_ex_flush=1; all other en=1.
  - Count down FILL_CYCLES cycles, then go to RUN and set booted=1.
  - flag_hold[2]=1 returns to IDLE with booted unchanged (warm-up restarts from full count).
- RUN: flag_hold[2]=1 returns to IDLE next cycle; current-cycle outputs are all en=0.
- RUN priority, highest first:
  - (a) freeze = mem_busy | flag_hold[1]: all en=0, no flush. If flag_flush=1 during freeze, set flush_pend=1.
  - (b) eff_flush = flag_flush | flush_pend: all en=1, if_id_flush=id_ex_flush=1. Clear flush_pend; flush_cnt+1.
  - (c) flag_hold[0]: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  - (d) normal: all en=1, no flush.
- Flush beats load-use hold: the ID instruction is wrong-path.
- flush_pend persists through IDLE; it is cleared only by application in RUN or by reset.
- Multiple flag_flush during one freeze collapse to one pending flush.
- stall_cnt increments in RUN when pc_en=0 (freeze or load-use). Both counters saturate at all-ones and never wrap.
- Reset assertion at any time returns immediately to reset values. An in-progress warm-up or pending flush is discarded.

Test Plan:
- Boot: reset, flag_hold=100 for 3 cycles, then 000 -> ctrl_state 00→01 for 4 cycles with if_id_flush=id_ex_flush=1 and pc_en=0, then 10 with all en=1.
- Load-use: RUN, flag_hold=001 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1 that cycle; stall_cnt=1.
- Flush vs load-use: flag_flush=1 and flag_hold=001 together -> if_id_flush=id_ex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Flush during freeze: mem_busy=1 for 3 cycles with flag_flush pulsed in cycle 2 -> all en=0 for 3 cycles, stall_cnt=3. The first cycle after mem_busy drops has if_id_flush=id_ex_flush=1 with flag_flush=0; flush_cnt=1.
- Resume after stop: RUN, flag_hold=100 for 2 cycles then 000 -> IDLE then directly RUN, no WARMUP.
- Saturation and reset: CNT_W=4, hold mem_busy 20 cycles -> stall_cnt=15. Assert sys_arstn=0 mid-WARMUP -> all outputs 0 and ctrl_state=00 immediately.
